// File: rtl/grid_painter.sv
// rtl/grid_painter.sv - snaps mouse clicks to a cell grid and paints/erases cells on the VGA framebuffer
module grid_painter #(
  parameter int COORD_W = 9,
  parameter int COLOR_W = 15,
  parameter int CELL_W  = 10,
  parameter int CELL_H  = 14,
  parameter int COLS    = 14,
  parameter int ROWS    = 14,
  parameter int X0      = 89,
  parameter int Y0      = 39,
  parameter logic [COLOR_W-1:0] DRAW_COLOR  = 15'h0000,
  parameter logic [COLOR_W-1:0] ERASE_COLOR = 15'h7FFF
) (
  input  logic                   CLOCK_50,
  input  logic                   count_reset,
  input  logic [COORD_W-1:0]     mouse_x,
  input  logic [COORD_W-1:0]     mouse_y,
  input  logic                   left_click,
  input  logic                   right_click,
  input  logic                   clear_all,
  output logic [COORD_W-1:0]     vga_x,
  output logic [COORD_W-1:0]     vga_y,
  output logic [COLOR_W-1:0]     vga_color,
  output logic                   vga_plot,
  output logic [ROWS*COLS-1:0]   cell_map,
  output logic                   busy,
  output logic                   map_changed
);

  localparam int IDX_W = $clog2(ROWS*COLS);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [COORD_W-1:0] CW  = COORD_W'(CELL_W);
  localparam logic [COORD_W-1:0] CH  = COORD_W'(CELL_H);
  localparam logic [COORD_W-1:0] GX0 = COORD_W'(X0);
  localparam logic [COORD_W-1:0] GY0 = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] GX1 = COORD_W'(X0 + COLS*CELL_W - 1);
  localparam logic [COORD_W-1:0] GY1 = COORD_W'(Y0 + ROWS*CELL_H - 1);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  typedef enum logic [2:0] {IDLE, SNAP, CHECK, FILL, CLEAR} state_t;

  state_t             state;
  logic [COORD_W-1:0] rem_x, rem_y;
  logic [COORD_W-1:0] base_x, base_y;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               draw_mode;

  logic               click, in_grid;
  logic [IDX_W-1:0]   cell_idx;
  logic [COORD_W-1:0] fill_x1, fill_y1;

  assign click    = left_click | right_click;
  assign in_grid  = (mouse_x >= GX0) && (mouse_x <= GX1) && (mouse_y >= GY0) && (mouse_y <= GY1);
  assign cell_idx = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
  assign fill_x1  = base_x + CW - ONE;
  assign fill_y1  = base_y + CH - ONE;

  // vga_x/vga_y double as the raster counters, so the plot outputs are live in the FILL/CLEAR states themselves
  always_ff @(posedge CLOCK_50) begin
    if (count_reset) begin
      state       <= IDLE;
      vga_plot    <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_color   <= '0;
      cell_map    <= '0;
      busy        <= 1'b0;
      map_changed <= 1'b0;
      rem_x       <= '0;
      rem_y       <= '0;
      base_x      <= '0;
      base_y      <= '0;
      col         <= '0;
      row         <= '0;
      draw_mode   <= 1'b0;
    end else begin
      map_changed <= 1'b0;
      case (state)
        IDLE: begin
          vga_plot <= 1'b0;
          if (clear_all) begin
            state       <= CLEAR;
            busy        <= 1'b1;
            map_changed <= |cell_map;
            cell_map    <= '0;
            vga_x       <= GX0;
            vga_y       <= GY0;
            vga_color   <= ERASE_COLOR;
            vga_plot    <= 1'b1;
          end else if (click && in_grid) begin
            state     <= SNAP;
            busy      <= 1'b1;
            rem_x     <= mouse_x - GX0;
            rem_y     <= mouse_y - GY0;
            base_x    <= GX0;
            base_y    <= GY0;
            col       <= '0;
            row       <= '0;
            draw_mode <= left_click;
          end
        end

        // both axes divide in parallel; base_x/base_y track the cell origin alongside
        SNAP: begin
          if (rem_x >= CW) begin
            rem_x  <= rem_x - CW;
            col    <= col + COL_W'(1);
            base_x <= base_x + CW;
          end
          if (rem_y >= CH) begin
            rem_y  <= rem_y - CH;
            row    <= row + ROW_W'(1);
            base_y <= base_y + CH;
          end
          if (rem_x < CW && rem_y < CH)
            state <= CHECK;
        end

        CHECK: begin
          if (cell_map[cell_idx] == draw_mode) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cell_map[cell_idx] <= draw_mode;
            map_changed        <= 1'b1;
            state              <= FILL;
            vga_x              <= base_x;
            vga_y              <= base_y;
            vga_color          <= draw_mode ? DRAW_COLOR : ERASE_COLOR;
            vga_plot           <= 1'b1;
          end
        end

        FILL: begin
          if (vga_x == fill_x1) begin
            if (vga_y == fill_y1) begin
              vga_plot <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              vga_x <= base_x;
              vga_y <= vga_y + ONE;
            end
          end else begin
            vga_x <= vga_x + ONE;
          end
        end

        CLEAR: begin
          if (vga_x == GX1) begin
            if (vga_y == GY1) begin
              vga_plot <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              vga_x <= GX0;
              vga_y <= vga_y + ONE;
            end
          end else begin
            vga_x <= vga_x + ONE;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          vga_plot <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_painter.sv
// tb/tb_grid_painter.sv - self-checking bench for grid_painter against a pixel-queue model
module tb_grid_painter;

  localparam int COORD_W = 9;
  localparam int COLOR_W = 15;
  localparam int CELL_W  = 10;
  localparam int CELL_H  = 14;
  localparam int COLS    = 14;
  localparam int ROWS    = 14;
  localparam int X0      = 89;
  localparam int Y0      = 39;
  localparam logic [COLOR_W-1:0] DRAW_C  = 15'h0000;
  localparam logic [COLOR_W-1:0] ERASE_C = 15'h7FFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  count_reset = 1'b1;
  logic [COORD_W-1:0]    mouse_x = '0, mouse_y = '0;
  logic                  left_click = 1'b0, right_click = 1'b0, clear_all = 1'b0;
  logic [COORD_W-1:0]    vga_x, vga_y;
  logic [COLOR_W-1:0]    vga_color;
  logic                  vga_plot, busy, map_changed;
  logic [ROWS*COLS-1:0]  cell_map;

  grid_painter dut (
    .CLOCK_50(clk), .count_reset(count_reset),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .left_click(left_click), .right_click(right_click), .clear_all(clear_all),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
    .cell_map(cell_map), .busy(busy), .map_changed(map_changed)
  );

  int errors = 0;
  int checks = 0;
  logic [32:0]          exp_q[$];
  logic [ROWS*COLS-1:0] model_map = '0;
  int exp_changes = 0, changes_seen = 0;
  int txn_plots = 0;
  logic [COORD_W-1:0] first_x, first_y, last_x, last_y;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_rect(input int x, input int y, input int w, input int h, input logic [COLOR_W-1:0] c);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        exp_q.push_back({COORD_W'(x + xx), COORD_W'(y + yy), c});
  endtask

  // Reference behaviour: plain division for the snap, whole-rectangle pixel lists for the fills
  task automatic model_click(input int x, input int y, input bit l, input bit r, input bit c);
    int cc, rr, idx;
    if (c) begin
      if (model_map != '0) exp_changes++;
      model_map = '0;
      push_rect(X0, Y0, COLS*CELL_W, ROWS*CELL_H, ERASE_C);
    end else if ((l || r) && x >= X0 && x < X0 + COLS*CELL_W && y >= Y0 && y < Y0 + ROWS*CELL_H) begin
      cc  = (x - X0) / CELL_W;
      rr  = (y - Y0) / CELL_H;
      idx = rr*COLS + cc;
      if (model_map[idx] != l) begin
        model_map[idx] = l;
        exp_changes++;
        push_rect(X0 + cc*CELL_W, Y0 + rr*CELL_H, CELL_W, CELL_H, l ? DRAW_C : ERASE_C);
      end
    end
  endtask

  always @(negedge clk) begin : compare
    logic [32:0] e;
    if (vga_plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_plot: got (%0d,%0d) color %0h, no plot expected", vga_x, vga_y, vga_color);
      end else begin
        e = exp_q.pop_front();
        check("plot_pixel", {vga_x, vga_y, vga_color}, e);
      end
      if (txn_plots == 0) begin
        first_x = vga_x;
        first_y = vga_y;
      end
      last_x = vga_x;
      last_y = vga_y;
      txn_plots++;
    end
    if (map_changed === 1'b1) changes_seen++;
  end

  task automatic wait_idle(input string name);
    int n = 0;
    #1;
    while (busy !== 1'b0 && n < 40000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 40000) check({name, "_timeout"}, busy, 0);
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_map"}, cell_map, model_map);
    check({name, "_changes"}, changes_seen, exp_changes);
  endtask

  task automatic do_click(input string name, input int x, input int y, input bit l, input bit r, input bit c);
    @(negedge clk);
    mouse_x = COORD_W'(x);
    mouse_y = COORD_W'(y);
    left_click = l; right_click = r; clear_all = c;
    txn_plots = 0;
    model_click(x, y, l, r, c);
    @(negedge clk);
    left_click = 0; right_click = 0; clear_all = 0;
    wait_idle(name);
  endtask

  initial begin
    int run, run_max, n, ch0;
    bit saw_busy;

    repeat (3) @(negedge clk);
    #1;
    check("rst_plot", vga_plot, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_color", vga_color, 0);
    check("rst_map", cell_map, 0);
    check("rst_busy", busy, 0);
    check("rst_changed", map_changed, 0);
    count_reset = 0;

    do_click("draw1", 100, 60, 1, 0, 0);
    check("draw1_count", txn_plots, 140);
    check("draw1_first", {first_x, first_y}, {9'd99, 9'd53});
    check("draw1_last", {last_x, last_y}, {9'd108, 9'd66});
    check("draw1_bit15", cell_map[15], 1);
    check("draw1_pulses", changes_seen, 1);

    @(negedge clk);
    mouse_x = 9'd100; mouse_y = 9'd60; left_click = 1;
    txn_plots = 0; run = 0; run_max = 0; saw_busy = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); #1;
      if (busy) begin
        run++;
        saw_busy = 1;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end
    end
    left_click = 0;
    @(negedge clk);
    wait_idle("hold");
    check("hold_busy_bounded", (saw_busy && run_max <= 3), 1);
    check("hold_plots", txn_plots, 0);

    do_click("erase1", 100, 60, 0, 1, 0);
    check("erase1_count", txn_plots, 140);
    check("erase1_first", {first_x, first_y, vga_color}, {9'd99, 9'd53, 15'h7FFF});
    check("erase1_bit15", cell_map[15], 0);

    do_click("left_out", 88, 60, 1, 0, 0);
    check("left_out_plots", txn_plots, 0);
    do_click("right_out", 229, 60, 1, 0, 0);
    check("right_out_plots", txn_plots, 0);

    do_click("corner", 228, 234, 1, 0, 0);
    check("corner_count", txn_plots, 140);
    check("corner_bit195", cell_map[195], 1);
    check("corner_first", {first_x, first_y}, {9'd219, 9'd221});

    do_click("redraw", 100, 60, 1, 0, 0);
    ch0 = changes_seen;
    do_click("clear1", 100, 60, 1, 0, 1);
    check("clear1_count", txn_plots, 27440);
    check("clear1_first", {first_x, first_y}, {9'd89, 9'd39});
    check("clear1_last", {last_x, last_y}, {9'd228, 9'd234});
    check("clear1_map", cell_map, 0);
    check("clear1_pulses", changes_seen - ch0, 1);

    ch0 = changes_seen;
    do_click("clear2", 120, 90, 0, 0, 1);
    check("clear2_count", txn_plots, 27440);
    check("clear2_pulses", changes_seen - ch0, 0);

    do_click("draw_pre", 100, 60, 1, 0, 0);
    @(negedge clk);
    mouse_x = 9'd150; mouse_y = 9'd100; left_click = 1;
    txn_plots = 0;
    model_click(150, 100, 1, 0, 0);
    @(negedge clk);
    left_click = 0;
    n = 0;
    #1;
    while (txn_plots < 50 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_mid_reached", txn_plots, 50);
    count_reset = 1;
    @(negedge clk); #1;
    check("rst_mid_plot", vga_plot, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_map", cell_map, 0);
    count_reset = 0;
    exp_q.delete();
    model_map = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mid_quiet", txn_plots, 50);

    do_click("after_rst", 100, 60, 1, 0, 0);
    check("after_rst_count", txn_plots, 140);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grid_painter.md
Name: grid_painter

Overview:
- Sequential canvas painter for the digit-drawing front end.
- Snaps a mouse coordinate to a parametrised ROWS x COLS cell grid and fills the selected cell on the VGA framebuffer in draw or erase colour.
- Maintains the cell occupancy bitmap consumed by the neural network.
- Sits between the mouse tracker and the VGA adapter. Adds erase-by-right-click, clear-all, duplicate-fill suppression and a live bitmap.

Parameters:
- COORD_W, 9, width of all pixel coordinates
- COLOR_W, 15, framebuffer colour width
- CELL_W, 10, cell width in pixels
- CELL_H, 14, cell height in pixels
- COLS, 14, grid columns
- ROWS, 14, grid rows
- X0, 89, leftmost grid pixel column
- Y0, 39, topmost grid pixel row
- DRAW_COLOR, 15'h0000, fill colour for set cells
- ERASE_COLOR, 15'h7FFF, fill colour for cleared cells

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge
- count_reset  in  1  synchronous, active-high reset
- mouse_x  in  COORD_W  pointer x, pixels
- mouse_y  in  COORD_W  pointer y, pixels
- left_click  in  1  level; paint cell under pointer
- right_click  in  1  level; erase cell under pointer
- clear_all  in  1  level; erase whole grid
- vga_x  out  COORD_W  pixel write x
- vga_y  out  COORD_W  pixel write y
- vga_color  out  COLOR_W  pixel write colour
- vga_plot  out  1  write strobe; one pixel per cycle high
- cell_map  out  ROWS*COLS  occupancy; bit index = row*COLS+col
- busy  out  1  high whenever not in IDLE
- map_changed  out  1  one-cycle pulse when cell_map changes

Behaviour:
- Reset: state IDLE; vga_plot=0, vga_x=0, vga_y=0, vga_color=0, cell_map=0, busy=0, map_changed=0. Reset mid-operation aborts immediately; no further plots from the next cycle. Screen contents are not touched.
- All outputs registered.
- FSM states: IDLE, SNAP, CHECK, FILL, CLEAR.
- IDLE: inputs sampled only here. Priority clear_all > left_click > right_click.
  - clear_all -> CLEAR.
  - Click with mouse inside [X0, X0+COLS*CELL_W-1] x [Y0, Y0+ROWS*CELL_H-1] -> latch dx=mouse_x-X0, dy=mouse_y-Y0 and mode (draw/erase) -> SNAP.
  - Click outside the grid is ignored; stay IDLE.
- SNAP: sequential divide by repeated subtraction.
  - Each cycle, an axis whose remainder is >= its cell size subtracts the cell size and increments its col/row counter.
  - Exit to CHECK on the first cycle both remainders are below cell size. Latency = max(col,row)+1 cycles.
- CHECK, 1 cycle:
  - If cell_map[row*COLS+col] already equals the target (1 draw, 0 erase), return to IDLE with no plots.
  - Otherwise update that bit, pulse map_changed and enter FILL.
- FILL: raster the cell left-to-right, then top-to-bottom, starting at (X0+col*CELL_W, Y0+row*CELL_H). One pixel per cycle with vga_plot=1, exactly CELL_W*CELL_H plots. vga_color is DRAW_COLOR or ERASE_COLOR per mode. Then IDLE.
- CLEAR: raster the full grid area with ERASE_COLOR, exactly COLS*CELL_W*ROWS*CELL_H plots. cell_map zeroed on entry. map_changed pulses on entry only if cell_map was nonzero. Then IDLE.
- Held clicks repaint continuously as the pointer moves. Duplicate suppression prevents redundant fills on a stationary pointer.
- Input changes during SNAP/CHECK/FILL/CLEAR are ignored. No input queueing.
- Width rule: all coordinate arithmetic in COORD_W bits. Parameters must satisfy X0+COLS*CELL_W <= 2^COORD_W, and likewise for y.

Test Plan (default parameters):
- Mouse (100,60) with left_click for one sample -> col=1, row=1, cell_map[15]=1, one map_changed pulse; 140 plots from (99,53) to (108,66) in raster order, colour 0x0000.
- Hold left_click at (100,60) after the first fill -> no further vga_plot, no map_changed, busy returns low within 3 cycles of each sample.
- Then right_click at (100,60) -> 140 plots, colour 0x7FFF, cell_map[15]=0.
- Edges:
  - (88,60) and (229,60) with left_click -> zero plots, cell_map unchanged.
  - (228,234) with left_click -> bit 195 set, first pixel (219,221).
- clear_all and left_click asserted together with bit 15 set -> 27440 plots, all 0x7FFF, from (89,39) to (228,234); cell_map=0, one map_changed.
- count_reset asserted at the 50th plot of a fill -> vga_plot=0 and busy=0 the next cycle, cell_map=0.
